pipelined_carry_adder: RTL

//  Parametrised, pipelined add/subtract unit; next generation of the team's 8-bit ripple adder.

---
 rtl/pipelined_carry_adder.sv | 118 +++++++++++
 1 files changed

// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder
// WIDTH-bit add/subtract unit built as STAGES ripple chunks. The carry
// between chunks is registered so the critical path is one chunk long.
// A valid/ready handshake runs on both sides, and the whole pipe stalls
// together under backpressure.
module pipelined_carry_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int C   = WIDTH / STAGES;
    localparam int MSB = WIDTH - 1;

    // Per-stage state. Each stage holds its valid bit and the carry out of
    // its chunk. It also holds the full-width sum, where the bits of chunks
    // up to and including its own are complete. Finally it holds the
    // operands, with b already inverted for subtract, so that later chunks
    // and the final overflow test see delay-aligned bits.
    logic             valid_q [STAGES];
    logic             valid_d [STAGES];
    logic             carry_q [STAGES];
    logic             carry_d [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] b_d     [STAGES];
    logic             ovf_q;
    logic             ovf_d;
    logic             advance_s;

    // The pipe moves whenever the output slot is empty or is being
    // consumed. Otherwise every stage holds.
    assign advance_s = ~valid_q[STAGES-1] | out_ready;
    assign in_ready  = advance_s;

    // Ripple each chunk using the carry registered by the previous stage.
    // Stage 0 takes the raw operands and the effective carry-in.
    always_comb begin
        logic             v_v;
        logic             c_v;
        logic [WIDTH-1:0] xa_v;
        logic [WIDTH-1:0] xb_v;
        logic [WIDTH-1:0] s_v;
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                v_v  = in_valid;
                xa_v = a;
                xb_v = sub ? ~b : b;
                c_v  = sub ? 1'b1 : cin;
                s_v  = {WIDTH{1'b0}};
            end else begin
                v_v  = valid_q[k-1];
                xa_v = a_q[k-1];
                xb_v = b_q[k-1];
                c_v  = carry_q[k-1];
                s_v  = sum_q[k-1];
            end
            for (int j = 0; j < C; j++) begin
                s_v[k*C+j] = xa_v[k*C+j] ^ xb_v[k*C+j] ^ c_v;
                c_v        = (xa_v[k*C+j] & xb_v[k*C+j]) |
                             (c_v & (xa_v[k*C+j] ^ xb_v[k*C+j]));
            end
            valid_d[k] = v_v;
            carry_d[k] = c_v;
            sum_d[k]   = s_v;
            a_d[k]     = xa_v;
            b_d[k]     = xb_v;
        end
        // Signed overflow: the operands share a sign and the result's sign differs.
        ovf_d = (a_d[STAGES-1][MSB] == b_d[STAGES-1][MSB]) &
                (sum_d[STAGES-1][MSB] != a_d[STAGES-1][MSB]);
    end

    // Stage registers. Reset flushes everything. A stall holds everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
                sum_q[k]   <= {WIDTH{1'b0}};
                a_q[k]     <= {WIDTH{1'b0}};
                b_q[k]     <= {WIDTH{1'b0}};
            end
            ovf_q <= 1'b0;
        end else if (advance_s) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= valid_d[k];
                carry_q[k] <= carry_d[k];
                sum_q[k]   <= sum_d[k];
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule
